// File: rtl/srm_mem_pkg.sv
// -----------------------------------------------------------------------------
// srm_mem_pkg
// Shared definitions for the single-port memory subsystem:
//   - MNONE / MREAD / MWRITE memory command encodings (2 bits)
//   - owner_t : which requester currently owns the memory port
//   - DEF_AW / DEF_DW : default address and data widths
// -----------------------------------------------------------------------------
package srm_mem_pkg;

   localparam int DEF_AW = 9;
   localparam int DEF_DW = 16;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CPU  = 2'b01,
      LDR  = 2'b10
   } owner_t;

endpackage : srm_mem_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one RAM port between the CPU controller and the program-loader/debug
// requester (LDR). The current owner keeps the port for as long as it keeps
// requesting, so multi-cycle CPU sequences are never split. Read data is
// steered back to whichever side issued the read, one cycle after issue.
//
// Optional feature (macro MEM_ARB_FAIR_EN): a hold counter forces a hand-over
// to the waiting side after MAX_HOLD consecutive owned cycles. Without the
// macro the owner keeps the port indefinitely and no counter exists.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   cpu_cmd/addr/wdata         CPU request (cmd != MNONE means request)
//   cpu_gnt                    CPU owns the port this cycle (combinational)
//   cpu_rdata/cpu_rvalid       read return to the CPU
//   ldr_cmd/addr/wdata         loader request, same encoding
//   ldr_gnt                    loader owns the port this cycle (combinational)
//   ldr_rdata/ldr_rvalid       read return to the loader
//   mem_cmd/addr/wdata         command to the RAM from the granted side
//   mem_rdata                  RAM read data, valid one cycle after MREAD
//   owner                      registered owner state (00 IDLE, 01 CPU, 10 LDR)
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import srm_mem_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   input  logic [1:0]    ldr_cmd,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_rvalid,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
);

   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("MAX_HOLD must be at least 1");
   end

   owner_t state_q, state_d;
   logic   rd_pend_q, rd_pend_d;
   logic   rd_who_q, rd_who_d;     // 1: pending read belongs to the loader
   logic   cpu_req, ldr_req;
   logic   cpu_g, ldr_g;
   logic   force_ho;               // owner must yield to the waiting side

   assign cpu_req = (cpu_cmd != MNONE);
   assign ldr_req = (ldr_cmd != MNONE);

`ifdef MEM_ARB_FAIR_EN
   localparam int HCW = $clog2(MAX_HOLD + 1);

   logic [HCW-1:0] hold_q, hold_d;

   // The hand-over is suppressed in the cycle right after a read issue so the
   // return cycle stays aligned with the issuer's own sequence.
   assign force_ho = (hold_q >= HCW'(MAX_HOLD)) && !rd_pend_q;

   // Counts consecutive granted cycles of one side while the other waits.
   // A grant to a side other than the registered owner starts a new run.
   always_comb begin
      hold_d = '0;
      if (cpu_g && ldr_req) begin
         if (state_q == CPU) begin
            hold_d = (hold_q < HCW'(MAX_HOLD)) ? hold_q + HCW'(1) : hold_q;
         end else begin
            hold_d = HCW'(1);
         end
      end else if (ldr_g && cpu_req) begin
         if (state_q == LDR) begin
            hold_d = (hold_q < HCW'(MAX_HOLD)) ? hold_q + HCW'(1) : hold_q;
         end else begin
            hold_d = HCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   assign force_ho = 1'b0;
`endif

   // Arbitration. Grants are held off while reset is asserted so no command
   // reaches the RAM during reset.
   // NOTE: every output of a combinational block gets a default first; any
   // path that skips an assignment would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cpu_g   = 1'b0;
      ldr_g   = 1'b0;
      if (reset) begin
         unique case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  cpu_g   = 1'b1;
                  state_d = CPU;
               end else if (ldr_req) begin
                  ldr_g   = 1'b1;
                  state_d = LDR;
               end
            end
            CPU: begin
               if (cpu_req && !(force_ho && ldr_req)) begin
                  cpu_g = 1'b1;
               end else if (ldr_req) begin
                  ldr_g   = 1'b1;
                  state_d = LDR;
               end else begin
                  state_d = IDLE;
               end
            end
            LDR: begin
               if (ldr_req && !(force_ho && cpu_req)) begin
                  ldr_g = 1'b1;
               end else if (cpu_req) begin
                  cpu_g   = 1'b1;
                  state_d = CPU;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Port mux: the granted side drives the RAM, otherwise the port is idle.
   always_comb begin
      mem_cmd   = MNONE;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_g) begin
         mem_cmd   = cpu_cmd;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (ldr_g) begin
         mem_cmd   = ldr_cmd;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
      end
   end

   // Read-return tracking: remember who issued the read this cycle.
   always_comb begin
      rd_pend_d = (mem_cmd == MREAD);
      rd_who_d  = ldr_g;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs regardless of block order.
   // The asynchronous reset also drops any read in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rd_pend_q <= 1'b0;
         rd_who_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         rd_who_q  <= rd_who_d;
      end
   end

   assign cpu_gnt    = cpu_g;
   assign ldr_gnt    = ldr_g;
   assign owner      = state_q;
   assign cpu_rvalid = rd_pend_q && !rd_who_q;
   assign ldr_rvalid = rd_pend_q && rd_who_q;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed, self-checking bench for mem_port_arbiter (default build, fair
// hand-over disabled). A small RAM model answers mem_* one cycle after MREAD.
// Expected read returns are pushed to a queue when a read is expected to be
// granted and popped in the following cycle. Inputs change 1 ns after the
// rising edge; outputs are sampled 4 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import srm_mem_pkg::*;

   localparam int AW = 9;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    cpu_cmd, ldr_cmd;
   logic [AW-1:0] cpu_addr, ldr_addr;
   logic [DW-1:0] cpu_wdata, ldr_wdata;
   logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
   logic [DW-1:0] cpu_rdata, ldr_rdata;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_cmd    (cpu_cmd),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .ldr_cmd    (ldr_cmd),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_gnt    (ldr_gnt),
      .ldr_rdata  (ldr_rdata),
      .ldr_rvalid (ldr_rvalid),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .owner      (owner)
   );

   function automatic logic [DW-1:0] seed(input int a);
      if (a == 'h010) return 16'hBEEF;
      return 16'h5A00 + DW'(a);
   endfunction

   // RAM model: loads itself on the first edge, then follows mem_*.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   bit            ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= seed(i);
         ram_loaded <= 1'b1;
      end else if (mem_cmd == MREAD) begin
         mem_rdata <= ram[mem_addr];
      end else if (mem_cmd == MWRITE) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   // Bench-side expectation of RAM contents and read returns.
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   typedef struct {
      bit            who;    // 1: loader
      logic [DW-1:0] data;
   } rd_exp_t;
   rd_exp_t sb [$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compares this cycle's read-return outputs against the scoreboard.
   task automatic check_returns(input string tag);
      rd_exp_t       e;
      logic          exp_cv = 1'b0, exp_lv = 1'b0;
      logic [DW-1:0] exp_cd = '0, exp_ld = '0;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.who) begin
            exp_lv = 1'b1;
            exp_ld = e.data;
         end else begin
            exp_cv = 1'b1;
            exp_cd = e.data;
         end
      end
      check({tag, " cpu_rvalid"}, cpu_rvalid, exp_cv);
      check({tag, " cpu_rdata"},  cpu_rdata,  exp_cd);
      check({tag, " ldr_rvalid"}, ldr_rvalid, exp_lv);
      check({tag, " ldr_rdata"},  ldr_rdata,  exp_ld);
   endtask

   // One clock cycle: drive both requesters, then check owner, grants, the
   // RAM-side mux and last cycle's read return; record expected effects.
   task automatic step(input string tag,
                       input logic [1:0] cc, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                       input logic [1:0] lc, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                       input logic [1:0] eo, input bit ecg, input bit elg);
      logic [1:0]    ec = MNONE;
      logic [AW-1:0] ea = '0;
      logic [DW-1:0] ew = '0;
      @(posedge clk);
      #1;
      cpu_cmd = cc; cpu_addr = ca; cpu_wdata = cw;
      ldr_cmd = lc; ldr_addr = la; ldr_wdata = lw;
      #3;
      if (ecg) begin
         ec = cc; ea = ca; ew = cw;
      end else if (elg) begin
         ec = lc; ea = la; ew = lw;
      end
      check_returns(tag);
      check({tag, " owner"},     owner,     eo);
      check({tag, " cpu_gnt"},   cpu_gnt,   ecg);
      check({tag, " ldr_gnt"},   ldr_gnt,   elg);
      check({tag, " mem_cmd"},   mem_cmd,   ec);
      check({tag, " mem_addr"},  mem_addr,  ea);
      check({tag, " mem_wdata"}, mem_wdata, ew);
      if (ec == MWRITE) shadow[ea] = ew;
      if (ec == MREAD)  sb.push_back('{who: elg, data: shadow[ea]});
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) shadow[i] = seed(i);
      reset   = 1'b0;
      cpu_cmd = MNONE; cpu_addr = '0; cpu_wdata = '0;
      ldr_cmd = MNONE; ldr_addr = '0; ldr_wdata = '0;

      // Reset state
      #3;
      check("reset owner",      owner,      2'b00);
      check("reset cpu_gnt",    cpu_gnt,    1'b0);
      check("reset ldr_gnt",    ldr_gnt,    1'b0);
      check("reset mem_cmd",    mem_cmd,    MNONE);
      check("reset cpu_rvalid", cpu_rvalid, 1'b0);
      check("reset ldr_rvalid", ldr_rvalid, 1'b0);
      #9 reset = 1'b1;

      // CPU two-cycle read of 0x010, returns one cycle later each
      step("cpu_rd1", MREAD, 9'h010, '0, MNONE, '0, '0, IDLE, 1'b1, 1'b0);
      step("cpu_rd2", MREAD, 9'h010, '0, MNONE, '0, '0, CPU,  1'b1, 1'b0);
      step("cpu_rel", MNONE, '0,     '0, MNONE, '0, '0, CPU,  1'b0, 1'b0);
      step("idle1",   MNONE, '0,     '0, MNONE, '0, '0, IDLE, 1'b0, 1'b0);

      // Simultaneous requests: CPU wins, loader follows with no gap
      step("both_req", MWRITE, 9'h020, 16'h1234, MREAD, 9'h030, '0, IDLE, 1'b1, 1'b0);
      step("ldr_take", MNONE,  '0,     '0,       MREAD, 9'h030, '0, CPU,  1'b0, 1'b1);
      step("ldr_rel",  MNONE,  '0,     '0,       MNONE, '0,     '0, LDR,  1'b0, 1'b0);
      step("idle2",    MNONE,  '0,     '0,       MNONE, '0,     '0, IDLE, 1'b0, 1'b0);

      // Loader owns and writes 0..9 while the CPU waits for all of them
      step("hold_pre", MNONE, '0, '0, MREAD, 9'h030, '0, IDLE, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("hold_wr%0d", i), MREAD, 9'h020, '0,
              MWRITE, AW'(i), 16'hC000 + DW'(i), LDR, 1'b0, 1'b1);
      end
      step("hold_hand", MREAD, 9'h020, '0, MNONE, '0, '0, LDR, 1'b1, 1'b0);
      step("hold_rel",  MNONE, '0,     '0, MNONE, '0, '0, CPU, 1'b0, 1'b0);
      step("idle3",     MNONE, '0,     '0, MNONE, '0, '0, IDLE, 1'b0, 1'b0);

      // Reset while a loader read is in flight: the read is discarded
      step("rst_rd_a", MNONE, '0, '0, MREAD, 9'h005, '0, IDLE, 1'b0, 1'b1);
      step("rst_rd_b", MNONE, '0, '0, MREAD, 9'h006, '0, LDR,  1'b0, 1'b1);
      #1 reset = 1'b0;
      sb.delete();
      #1;
      check("rst_async owner",      owner,      2'b00);
      check("rst_async ldr_rvalid", ldr_rvalid, 1'b0);
      check("rst_async ldr_rdata",  ldr_rdata,  '0);
      ldr_cmd = MNONE; ldr_addr = '0;
      @(posedge clk);
      #4;
      check("rst_hold ldr_rvalid", ldr_rvalid, 1'b0);
      check("rst_hold owner",      owner,      2'b00);
      #1 reset = 1'b1;
      step("rst_after", MNONE, '0, '0, MNONE, '0, '0, IDLE, 1'b0, 1'b0);

      // Interleaved reads on consecutive cycles, routed to each issuer in order
      step("il_cpu1", MREAD, 9'h010, '0, MNONE, '0,     '0, IDLE, 1'b1, 1'b0);
      step("il_ldr",  MNONE, '0,     '0, MREAD, 9'h009, '0, CPU,  1'b0, 1'b1);
      step("il_cpu2", MREAD, 9'h020, '0, MNONE, '0,     '0, LDR,  1'b1, 1'b0);
      step("il_rel",  MNONE, '0,     '0, MNONE, '0,     '0, CPU,  1'b0, 1'b0);
      step("il_idle", MNONE, '0,     '0, MNONE, '0,     '0, IDLE, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (mem_cmd/mem_addr/write data/read data) between the CPU controller and a program-loader/debug requester (LDR).
- Sits between the CPU datapath/controller and the RAM. Lets the loader write programs or inspect memory without a separate RAM port.
- Owner is held for consecutive requests, so multi-cycle CPU sequences (IF1→IF2, LDR4→LDR5) are never split.
- Read data is routed back to the requester that issued the read.

Parameters:
AW, 9, memory address width
DW, 16, memory data width
MAX_HOLD, 8, consecutive owned cycles before forced hand-over (used only with MEM_ARB_FAIR_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_cmd  in  2  CPU command: 00 MNONE, 01 MREAD, 10 MWRITE; non-MNONE = request
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU owns port this cycle (combinational)
cpu_rdata  out  DW  read data to CPU
cpu_rvalid  out  1  cpu_rdata valid (one cycle after granted MREAD)
ldr_cmd  in  2  loader command, same encoding
ldr_addr  in  AW  loader address
ldr_wdata  in  DW  loader write data
ldr_gnt  out  1  loader owns port this cycle (combinational)
ldr_rdata  out  DW  read data to loader
ldr_rvalid  out  1  ldr_rdata valid
mem_cmd  out  2  command to RAM
mem_addr  out  AW  address to RAM
mem_wdata  out  DW  write data to RAM
mem_rdata  in  DW  RAM read data, valid one cycle after MREAD
owner  out  2  registered state: 00 IDLE, 01 CPU, 10 LDR

Behaviour:
- FSM states: IDLE, OWN_CPU, OWN_LDR. State is registered.
- Grant is combinational from the state and the current commands. mem_* is muxed from the granted requester, or MNONE/0 when nothing is granted.
- IDLE:
  - cpu_cmd≠MNONE → cpu_gnt=1 the same cycle; next state OWN_CPU.
  - else ldr_cmd≠MNONE → ldr_gnt=1; next state OWN_LDR.
  - Both request → CPU wins.
- OWN_x:
  - Owner request present → owner granted; stay.
  - Owner cmd=MNONE → other side granted the same cycle if requesting (next OWN_other), else no grant and next IDLE.
- A non-granted requester sees gnt=0 and must hold cmd/addr/wdata stable until granted. The arbiter never drops or reorders a waiting request.
- Read return:
  - Register rd_pend (1b) and rd_who (1b) on every granted MREAD.
  - Next cycle, assert the matching x_rvalid=1 and drive x_rdata=mem_rdata. The other side's rdata is 0.
  - Back-to-back reads pipeline: one return per cycle.
- Writes: mem_cmd=MWRITE for exactly the granted cycle; no response.
- Simultaneous events: release by owner plus request by the other side in the same cycle → other side is granted that cycle, with no dead cycle.
- Reset (asserted, async):
  - state=IDLE; rd_pend=0; hold counter=0.
  - Registered outputs (owner, x_rvalid, x_rdata) are forced to 0 immediately.
  - A read in flight when reset asserts is discarded (no rvalid after release).
- After reset deasserts, arbitration resumes from IDLE on the next edge.

Optional Feature:
- MEM_ARB_FAIR_EN defined:
  - A hold counter counts consecutive granted cycles of the current owner while the other side is requesting.
  - When the count reaches MAX_HOLD, the next cycle grants the other side (if still requesting) and the counter clears.
  - The counter also clears on any ownership change or when the other side stops requesting.
  - A forced hand-over never occurs in the cycle after a granted MREAD's issue cycle. A pending rvalid is still delivered to the original issuer.
- Undefined: strict CPU priority whenever the CPU requests from IDLE, and no forced hand-over. The owner keeps the port indefinitely while requesting, and the counter logic is absent.

Decomposition:
- Shared package srm_mem_pkg holds:
  - MNONE/MREAD/MWRITE 2-bit constants
  - owner_t enum (IDLE, CPU, LDR)
  - default AW/DW widths
- No sub-module; the FSM, output mux and read-return tracking fit in one module.

Test Plan:
- Reset with mem_cmd idle → owner=00, cpu_gnt=ldr_gnt=0, mem_cmd=00, both rvalid=0.
- cpu_cmd=MREAD addr 0x010 for 2 cycles; RAM returns 0xBEEF → cpu_gnt=1 both cycles, owner=01, cpu_rvalid=1 on cycles 2–3 with cpu_rdata=0xBEEF, ldr_rvalid=0.
- Same cycle: cpu_cmd=MWRITE addr 0x020 data 0x1234 and ldr_cmd=MREAD addr 0x030 → CPU granted first, mem_cmd=10. Loader is granted the cycle after the CPU drops to MNONE, with no idle gap.
- Loader owns and writes 0x0000..0x0009 continuously while CPU requests:
  - Without MEM_ARB_FAIR_EN: the CPU waits all 10 cycles.
  - With MEM_ARB_FAIR_EN and MAX_HOLD=8: the CPU is granted on cycle 9.
- Loader MREAD granted, then reset asserted before the return cycle → ldr_rvalid stays 0; owner=00 immediately.
- Interleaved CPU read / loader read / CPU read on consecutive cycles (via releases) → each rvalid is routed to its issuer, one cycle later, in order.
